// File: rtl/mips32_pkg.sv
// Shared constants and encodings for the mips32 core pipeline.
package mips32_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   typedef enum logic [1:0] {
      LS_WORD = 2'b00,
      LS_HALF = 2'b01,
      LS_BYTE = 2'b10,
      LS_RSVD = 2'b11
   } load_size_e;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT_LOAD
   } wb_state_e;

endpackage

// File: rtl/load_formatter.sv
// Selects the little-endian byte/half lane of a data-memory word and
// sign- or zero-extends it to the datapath width.
module load_formatter
   import mips32_pkg::*;
#(
   parameter int unsigned DATA_W = mips32_pkg::DATA_W
) (
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        size,
   input  logic              is_signed,
   input  logic [1:0]        byte_off,
   output logic [DATA_W-1:0] value
);

   logic [7:0]  lane8;
   logic [15:0] lane16;

   always_comb begin
      lane8  = rdata[{byte_off, 3'b000} +: 8];
      lane16 = rdata[{byte_off[1], 4'b0000} +: 16];
      value  = rdata;
      case (load_size_e'(size))
         LS_HALF: value = {{(DATA_W-16){is_signed & lane16[15]}}, lane16};
         LS_BYTE: value = {{(DATA_W-8){is_signed & lane8[7]}}, lane8};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB stage: registers ALU results, waits on data-memory loads with a
// ready handshake, and drives the register bank write port plus forward tap.
module writeback_stage
   import mips32_pkg::*;
#(
   parameter int unsigned DATA_W = mips32_pkg::DATA_W,
   parameter int unsigned ADDR_W = mips32_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid,
   input  logic              mem_regWrite,
   input  logic              mem_memToReg,
   input  logic [1:0]        mem_loadSize,
   input  logic              mem_loadSigned,
   input  logic [1:0]        mem_byteOff,
   input  logic [DATA_W-1:0] mem_aluResult,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic              regWrite,
   output logic [ADDR_W-1:0] rWriteAddress,
   output logic [DATA_W-1:0] rWriteValue,
   output logic              stall,
   output logic              fwdValid,
   output logic [ADDR_W-1:0] fwdAddress,
   output logic [DATA_W-1:0] fwdValue
);

   wb_state_e         state_q, state_d;
   logic              reg_write_q, reg_write_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              ld_we_q, ld_we_d;
   logic [ADDR_W-1:0] ld_rd_q, ld_rd_d;
   logic [1:0]        ld_size_q, ld_size_d;
   logic              ld_signed_q, ld_signed_d;
   logic [1:0]        ld_off_q, ld_off_d;

   logic [DATA_W-1:0] fmt_value;

   load_formatter #(.DATA_W(DATA_W)) u_fmt (
      .rdata     (dmem_rdata),
      .size      (ld_size_q),
      .is_signed (ld_signed_q),
      .byte_off  (ld_off_q),
      .value     (fmt_value)
   );

   always_comb begin
      state_d     = state_q;
      reg_write_d = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      ld_we_d     = ld_we_q;
      ld_rd_d     = ld_rd_q;
      ld_size_d   = ld_size_q;
      ld_signed_d = ld_signed_q;
      ld_off_d    = ld_off_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_valid) begin
               if (mem_memToReg) begin
                  ld_we_d     = mem_regWrite;
                  ld_rd_d     = mem_rd;
                  ld_size_d   = mem_loadSize;
                  ld_signed_d = mem_loadSigned;
                  ld_off_d    = mem_byteOff;
                  state_d     = ST_WAIT_LOAD;
               end else begin
                  reg_write_d = mem_regWrite && (mem_rd != '0);
                  waddr_d     = mem_rd;
                  wdata_d     = mem_aluResult;
               end
            end
         end
         ST_WAIT_LOAD: begin
            // mem_valid is ignored here: upstream is holding the load itself
            if (dmem_ready) begin
               reg_write_d = ld_we_q && (ld_rd_q != '0);
               waddr_d     = ld_rd_q;
               wdata_d     = fmt_value;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         reg_write_q <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         ld_we_q     <= 1'b0;
         ld_rd_q     <= '0;
         ld_size_q   <= '0;
         ld_signed_q <= 1'b0;
         ld_off_q    <= '0;
      end else begin
         state_q     <= state_d;
         reg_write_q <= reg_write_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         ld_we_q     <= ld_we_d;
         ld_rd_q     <= ld_rd_d;
         ld_size_q   <= ld_size_d;
         ld_signed_q <= ld_signed_d;
         ld_off_q    <= ld_off_d;
      end
   end

   // Combinational so it falls with dmem_ready and with reset.
   assign stall         = (state_q == ST_WAIT_LOAD) && !dmem_ready;

   assign regWrite      = reg_write_q;
   assign rWriteAddress = waddr_q;
   assign rWriteValue   = wdata_q;
   assign fwdValid      = reg_write_q;
   assign fwdAddress    = waddr_q;
   assign fwdValue      = wdata_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table plus multi-cycle sequences.
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_regWrite, mem_memToReg, mem_loadSigned;
   logic [1:0]  mem_loadSize, mem_byteOff;
   logic [31:0] mem_aluResult, dmem_rdata;
   logic [4:0]  mem_rd;
   logic        dmem_ready;
   logic        regWrite, stall, fwdValid;
   logic [4:0]  rWriteAddress, fwdAddress;
   logic [31:0] rWriteValue, fwdValue;

   int n_tests = 0;
   int n_fail  = 0;

   writeback_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_valid      (mem_valid),
      .mem_regWrite   (mem_regWrite),
      .mem_memToReg   (mem_memToReg),
      .mem_loadSize   (mem_loadSize),
      .mem_loadSigned (mem_loadSigned),
      .mem_byteOff    (mem_byteOff),
      .mem_aluResult  (mem_aluResult),
      .mem_rd         (mem_rd),
      .dmem_rdata     (dmem_rdata),
      .dmem_ready     (dmem_ready),
      .regWrite       (regWrite),
      .rWriteAddress  (rWriteAddress),
      .rWriteValue    (rWriteValue),
      .stall          (stall),
      .fwdValid       (fwdValid),
      .fwdAddress     (fwdAddress),
      .fwdValue       (fwdValue)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        is_load;
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [1:0]  off;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic [31:0] rdata;
      logic        exp_we;
      logic [31:0] exp_val;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_write(input string name, input logic we, input logic [4:0] addr,
                              input logic [31:0] val);
      check({name, ".regWrite"}, 32'(regWrite), 32'(we));
      check({name, ".addr"}, 32'(rWriteAddress), 32'(addr));
      check({name, ".value"}, rWriteValue, val);
      check({name, ".fwdValid"}, 32'(fwdValid), 32'(we));
      check({name, ".fwdAddr"}, 32'(fwdAddress), 32'(addr));
      check({name, ".fwdValue"}, fwdValue, val);
   endtask

   task automatic drive_idle();
      mem_valid      = 1'b0;
      mem_regWrite   = 1'b0;
      mem_memToReg   = 1'b0;
      mem_loadSize   = 2'b00;
      mem_loadSigned = 1'b0;
      mem_byteOff    = 2'b00;
      mem_aluResult  = '0;
      mem_rd         = '0;
   endtask

   task automatic drive_op(input logic is_load, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [1:0] off, input logic [31:0] alu,
                           input logic [4:0] rd);
      mem_valid      = 1'b1;
      mem_regWrite   = we;
      mem_memToReg   = is_load;
      mem_loadSize   = size;
      mem_loadSigned = sgn;
      mem_byteOff    = off;
      mem_aluResult  = alu;
      mem_rd         = rd;
   endtask

   initial begin
      rst        = 1'b0;
      dmem_ready = 1'b0;
      dmem_rdata = '0;
      drive_idle();

      // Reset state
      #12;
      check("reset.regWrite", 32'(regWrite), 32'd0);
      check("reset.addr", 32'(rWriteAddress), 32'd0);
      check("reset.value", rWriteValue, 32'd0);
      check("reset.stall", 32'(stall), 32'd0);
      check("reset.fwdValid", 32'(fwdValid), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      vq.push_back('{"alu_rd5",   1'b0, 1'b1, 2'b00, 1'b0, 2'd0, 32'h1234_5678, 5'd5,  32'h0,         1'b1, 32'h1234_5678});
      vq.push_back('{"lb_off3",   1'b1, 1'b1, 2'b10, 1'b1, 2'd3, 32'h0,         5'd6,  32'h80FF_7F01, 1'b1, 32'hFFFF_FF80});
      vq.push_back('{"lbu_off1",  1'b1, 1'b1, 2'b10, 1'b0, 2'd1, 32'h0,         5'd7,  32'h80FF_7F01, 1'b1, 32'h0000_007F});
      vq.push_back('{"lh_off2",   1'b1, 1'b1, 2'b01, 1'b1, 2'd2, 32'h0,         5'd8,  32'h80FF_7F01, 1'b1, 32'hFFFF_80FF});
      vq.push_back('{"lhu_off0",  1'b1, 1'b1, 2'b01, 1'b0, 2'd0, 32'h0,         5'd9,  32'h80FF_7F01, 1'b1, 32'h0000_7F01});
      vq.push_back('{"lw",        1'b1, 1'b1, 2'b00, 1'b1, 2'd3, 32'h0,         5'd10, 32'h80FF_7F01, 1'b1, 32'h80FF_7F01});
      vq.push_back('{"l_rsvd",    1'b1, 1'b1, 2'b11, 1'b1, 2'd1, 32'h0,         5'd11, 32'h80FF_7F01, 1'b1, 32'h80FF_7F01});
      vq.push_back('{"lh_off3",   1'b1, 1'b1, 2'b01, 1'b1, 2'd3, 32'h0,         5'd12, 32'h80FF_7F01, 1'b1, 32'hFFFF_80FF});
      vq.push_back('{"lb_off0",   1'b1, 1'b1, 2'b10, 1'b1, 2'd0, 32'h0,         5'd13, 32'h80FF_7F01, 1'b1, 32'h0000_0001});
      vq.push_back('{"lbu_off3",  1'b1, 1'b1, 2'b10, 1'b0, 2'd3, 32'h0,         5'd14, 32'h80FF_7F01, 1'b1, 32'h0000_0080});
      vq.push_back('{"lb_off2",   1'b1, 1'b1, 2'b10, 1'b1, 2'd2, 32'h0,         5'd15, 32'h80FF_7F01, 1'b1, 32'hFFFF_FFFF});
      vq.push_back('{"lhu_off1",  1'b1, 1'b1, 2'b01, 1'b0, 2'd1, 32'h0,         5'd16, 32'h1234_8001, 1'b1, 32'h0000_8001});
      vq.push_back('{"alu_rd0",   1'b0, 1'b1, 2'b00, 1'b0, 2'd0, 32'hA5A5_0F0F, 5'd0,  32'h0,         1'b0, 32'hA5A5_0F0F});
      vq.push_back('{"alu_nowe",  1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0000_0042, 5'd17, 32'h0,         1'b0, 32'h0000_0042});
      vq.push_back('{"ld_nowe",   1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h0,         5'd18, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D});
      vq.push_back('{"ld_rd0",    1'b1, 1'b1, 2'b10, 1'b0, 2'd2, 32'h0,         5'd0,  32'h00EE_0000, 1'b0, 32'h0000_00EE});

      foreach (vq[i]) begin
         @(negedge clk);
         drive_op(vq[i].is_load, vq[i].we, vq[i].size, vq[i].sgn, vq[i].off, vq[i].alu, vq[i].rd);
         dmem_rdata = vq[i].rdata;
         dmem_ready = 1'b0;
         @(posedge clk);
         #1;
         if (vq[i].is_load) begin
            check({vq[i].name, ".stall_wait"}, 32'(stall), 32'd1);
            check({vq[i].name, ".no_early_write"}, 32'(regWrite), 32'd0);
            @(negedge clk);
            dmem_ready = 1'b1;
            #1;
            check({vq[i].name, ".stall_ready"}, 32'(stall), 32'd0);
            @(posedge clk);
            #1;
         end
         check_write(vq[i].name, vq[i].exp_we, vq[i].rd, vq[i].exp_val);
         @(negedge clk);
         drive_idle();
         dmem_ready = 1'b0;
         @(posedge clk);
         #1;
         check({vq[i].name, ".pulse_end"}, 32'(regWrite), 32'd0);
      end

      // Load word with three wait cycles; held instruction must not re-issue
      @(negedge clk);
      drive_op(1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 32'h0000_0BAD, 5'd20);
      dmem_rdata = 32'hDEAD_BEEF;
      dmem_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("lw3.stall%0d", c), 32'(stall), 32'd1);
         check($sformatf("lw3.nowrite%0d", c), 32'(regWrite), 32'd0);
      end
      @(negedge clk);
      dmem_ready = 1'b1;
      #1;
      check("lw3.stall_drop", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      check_write("lw3", 1'b1, 5'd20, 32'hDEAD_BEEF);
      @(negedge clk);
      drive_idle();
      dmem_ready = 1'b0;
      @(posedge clk);
      #1;
      check("lw3.pulse_end", 32'(regWrite), 32'd0);

      // Back-to-back ALU ops
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         drive_op(1'b0, 1'b1, 2'b00, 1'b0, 2'd0, 32'h1000_0000 + 32'(k), 5'(k));
         @(posedge clk);
         #1;
         check_write($sformatf("b2b%0d", k), 1'b1, 5'(k), 32'h1000_0000 + 32'(k));
      end
      @(negedge clk);
      drive_idle();
      @(posedge clk);
      #1;
      check("b2b.end", 32'(regWrite), 32'd0);

      // Reset during WAIT_LOAD
      @(negedge clk);
      drive_op(1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 32'h0, 5'd21);
      dmem_rdata = 32'h5555_AAAA;
      dmem_ready = 1'b0;
      @(posedge clk);
      #1;
      check("rstwait.stall_before", 32'(stall), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check("rstwait.stall_async", 32'(stall), 32'd0);
      check("rstwait.regWrite_async", 32'(regWrite), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      drive_idle();
      dmem_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("rstwait.nowrite%0d", c), 32'(regWrite), 32'd0);
         check($sformatf("rstwait.nostall%0d", c), 32'(stall), 32'd0);
      end

      // dmem_ready held high: ready in IDLE ignored, write one edge after capture
      @(negedge clk);
      drive_op(1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 32'h0, 5'd22);
      dmem_rdata = 32'hCAFE_F00D;
      dmem_ready = 1'b1;
      #1;
      check("rdyhi.stall_idle", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      check("rdyhi.stall_wait", 32'(stall), 32'd0);
      check("rdyhi.nowrite", 32'(regWrite), 32'd0);
      @(negedge clk);
      drive_idle();
      @(posedge clk);
      #1;
      check_write("rdyhi", 1'b1, 5'd22, 32'hCAFE_F00D);
      check("rdyhi.stall_write", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      check("rdyhi.pulse_end", 32'(regWrite), 32'd0);
      dmem_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
